// File: rtl/spi_pkg.sv
// Shared SPI link definitions for spi_send_con / spi_receive_con.
// Receiver state encoding and default frame constants.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_DUTY_CYCLE = 50;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WAIT_END
  } spi_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a per-instance reset value.
// Async active-low reset; WIDTH bits move in lockstep.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_receive_con.sv
// SPI receiver: syncs CIPO/DCLK/CS, shifts MSB-first words per line.
// Optional SPI_RX_FRAME_CHECK_EN enables the frame_err_out pulse.
module spi_receive_con
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH      = SPI_DATA_WIDTH,
  parameter int LINES           = 1,
  parameter int DATA_WIDTH_SIZE = $clog2(DATA_WIDTH + 1)
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [LINES-1:0]                 chip_data_in,
  input  logic                             chip_clk_in,
  input  logic                             chip_sel_in,
  output logic [LINES-1:0][DATA_WIDTH-1:0] data_out,
  output logic                             data_valid_out,
  output logic                             frame_err_out
);

  localparam logic [DATA_WIDTH_SIZE-1:0] LAST =
    DATA_WIDTH_SIZE'(DATA_WIDTH - 1);

  typedef logic [LINES-1:0][DATA_WIDTH-1:0] word_t;

  logic [LINES-1:0]           data_s;
  logic                       clk_s;
  logic                       cs_s;
  logic                       clk_q;
  logic                       rise;
  logic [1:0]                 warm;
  logic                       armed;

  spi_rx_state_t              state, state_n;
  word_t                      sreg, sreg_n, shifted, data_n;
  logic [DATA_WIDTH_SIZE-1:0] count, count_n;
  logic                       valid_n;

  sync_2ff #(.WIDTH(LINES), .RST_VAL('0)) u_sync_data (
    .clk(clk_in), .rst_n(rst_n_in),
    .d(chip_data_in), .q(data_s)
  );

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_clk (
    .clk(clk_in), .rst_n(rst_n_in),
    .d(chip_clk_in), .q(clk_s)
  );

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk_in), .rst_n(rst_n_in),
    .d(chip_sel_in), .q(cs_s)
  );

  assign rise = clk_s & ~clk_q;

`ifdef SPI_RX_FRAME_CHECK_EN
  logic err_q, err_n, done, done_n;
  assign frame_err_out = err_q;
`else
  assign frame_err_out = 1'b0;
`endif

  // Candidate shift result: new bit enters at the LSB of each line.
  always_comb begin
    shifted = sreg;
    for (int l = 0; l < LINES; l++) begin
      shifted[l] = {sreg[l][DATA_WIDTH-2:0], data_s[l]};
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    count_n = count;
    data_n  = data_out;
    valid_n = 1'b0;
`ifdef SPI_RX_FRAME_CHECK_EN
    err_n   = 1'b0;
    done_n  = done;
`endif
    unique case (state)
      IDLE: begin
        if (!cs_s && armed) begin
          state_n = RECV;
          sreg_n  = '0;
          count_n = '0;
        end
      end
      RECV: begin
        if (cs_s) begin
          state_n = IDLE;
`ifdef SPI_RX_FRAME_CHECK_EN
          err_n   = (count != '0);
`endif
        end else if (rise) begin
          sreg_n  = shifted;
          count_n = count + 1'b1;
          if (count == LAST) begin
            data_n  = shifted;
            valid_n = 1'b1;
            state_n = WAIT_END;
`ifdef SPI_RX_FRAME_CHECK_EN
            done_n  = 1'b0;
`endif
          end
        end
      end
      WAIT_END: begin
        if (cs_s) begin
          state_n = IDLE;
        end
`ifdef SPI_RX_FRAME_CHECK_EN
        else if (rise && !done) begin
          err_n  = 1'b1;
          done_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      sreg           <= '0;
      count          <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      clk_q          <= 1'b0;
      warm           <= '0;
      armed          <= 1'b0;
`ifdef SPI_RX_FRAME_CHECK_EN
      err_q          <= 1'b0;
      done           <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      sreg           <= sreg_n;
      count          <= count_n;
      data_out       <= data_n;
      data_valid_out <= valid_n;
      clk_q          <= clk_s;
      // Arm only once a real CS-high has crossed the synchronizer.
      warm           <= {warm[0], 1'b1};
      if (state == IDLE && cs_s && warm[1]) begin
        armed <= 1'b1;
      end
`ifdef SPI_RX_FRAME_CHECK_EN
      err_q          <= err_n;
      done           <= done_n;
`endif
    end
  end

endmodule

// File: tb/tb_spi_receive_con.sv
// Directed bench for spi_receive_con (LINES = 2).
// Expectations adapt to SPI_RX_FRAME_CHECK_EN.
module tb_spi_receive_con;
  import spi_pkg::*;

  localparam int DW   = 8;
  localparam int LN   = 2;
  localparam int PER  = 8;
  localparam int HI   = PER * SPI_DUTY_CYCLE / 100;
  localparam int LO   = PER - HI;
`ifdef SPI_RX_FRAME_CHECK_EN
  localparam int EE = 1;
`else
  localparam int EE = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [LN-1:0]           sdata = '0;
  logic                    sclk = 1'b0;
  logic                    cs = 1'b1;
  logic [LN-1:0][DW-1:0]   data_out;
  logic                    valid;
  logic                    err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nvalid = 0;
  int nerr = 0;
  int both = 0;
  int vcyc = 0;
  int rise_cyc = 0;

  spi_receive_con #(.DATA_WIDTH(DW), .LINES(LN)) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .chip_data_in(sdata),
    .chip_clk_in(sclk),
    .chip_sel_in(cs),
    .data_out(data_out),
    .data_valid_out(valid),
    .frame_err_out(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      nvalid++;
      vcyc = cyc;
    end
    if (err) nerr++;
    if (valid && err) both++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic put_bit(input logic [7:0] w0, input logic [7:0] w1,
                         input int i);
    sdata[0] = (i < DW) ? w0[3'(DW - 1 - i)] : 1'b0;
    sdata[1] = (i < DW) ? w1[3'(DW - 1 - i)] : 1'b0;
    repeat (LO) @(negedge clk);
    sclk = 1'b1;
    rise_cyc = cyc;
    repeat (HI) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send(input logic [7:0] w0, input logic [7:0] w1,
                      input int nbits);
    @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) put_bit(w0, w1, i);
    repeat (LO) @(negedge clk);
    cs = 1'b1;
    sdata = '0;
    repeat (2 * PER) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    int         nbits;
    int         ev;
    int         ee;
    logic [7:0] d0;
    logic [7:0] d1;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int v0, e0;
    tbl[0] = '{8'hA5, 8'h5A, 8, 1, 0,  8'hA5, 8'h5A};
    tbl[1] = '{8'h3C, 8'hC3, 8, 1, 0,  8'h3C, 8'hC3};
    tbl[2] = '{8'h01, 8'hFE, 8, 1, 0,  8'h01, 8'hFE};
    tbl[3] = '{8'h80, 8'h7F, 8, 1, 0,  8'h80, 8'h7F};
    tbl[4] = '{8'hFF, 8'h00, 8, 1, 0,  8'hFF, 8'h00};
    tbl[5] = '{8'hFF, 8'hFF, 5, 0, EE, 8'hFF, 8'h00};
    tbl[6] = '{8'h5A, 8'hA5, 8, 1, 0,  8'h5A, 8'hA5};
    tbl[7] = '{8'h12, 8'h34, 0, 0, 0,  8'h5A, 8'hA5};

    repeat (3) @(negedge clk);
    check("rst_data", int'(data_out), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      v0 = nvalid;
      e0 = nerr;
      send(tbl[k].w0, tbl[k].w1, tbl[k].nbits);
      check($sformatf("v%0d_valid", k), nvalid - v0, tbl[k].ev);
      check($sformatf("v%0d_err", k), nerr - e0, tbl[k].ee);
      check($sformatf("v%0d_d0", k), int'(data_out[0]), int'(tbl[k].d0));
      check($sformatf("v%0d_d1", k), int'(data_out[1]), int'(tbl[k].d1));
      if (tbl[k].ev == 1) begin
        check($sformatf("v%0d_lat", k),
              int'((vcyc - rise_cyc) >= 1 && (vcyc - rise_cyc) <= 4), 1);
      end
    end

    v0 = nvalid;
    e0 = nerr;
    @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < 3; i++) put_bit(8'hC6, 8'h39, i);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_data", int'(data_out), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    cs = 1'b1;
    sdata = '0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_pulses", (nvalid - v0) + (nerr - e0), 0);
    v0 = nvalid;
    send(8'hC6, 8'h39, 8);
    check("post_rst_valid", nvalid - v0, 1);
    check("post_rst_d0", int'(data_out[0]), 'hC6);
    check("post_rst_d1", int'(data_out[1]), 'h39);

    v0 = nvalid;
    e0 = nerr;
    send(8'h33, 8'hCC, 9);
    check("extra_valid", nvalid - v0, 1);
    check("extra_err", nerr - e0, EE);
    check("extra_d0", int'(data_out[0]), 'h33);
    check("extra_d1", int'(data_out[1]), 'hCC);

    check("valid_err_excl", both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
